// File: rtl/tmu2_fmlarb.sv
// Two-master round-robin arbiter in front of one FML burst port (4 beats x 64b).
// One master is granted per burst; the grant is held until its last data beat has passed.
module tmu2_fmlarb #(
    parameter int fml_depth  = 26,
    parameter int rd_latency = 1
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    output logic                 busy,

    input  logic [fml_depth-1:0] m0_adr,
    input  logic                 m0_stb,
    input  logic                 m0_we,
    input  logic [7:0]           m0_sel,
    input  logic [63:0]          m0_do,
    output logic                 m0_ack,

    input  logic [fml_depth-1:0] m1_adr,
    input  logic                 m1_stb,
    input  logic                 m1_we,
    input  logic [7:0]           m1_sel,
    input  logic [63:0]          m1_do,
    output logic                 m1_ack,

    output logic [fml_depth-1:0] fml_adr,
    output logic                 fml_stb,
    output logic                 fml_we,
    input  logic                 fml_ack,
    output logic [7:0]           fml_sel,
    output logic [63:0]          fml_do
);

    // Counter must hold rd_latency+3, never narrower than 3 bits.
    localparam int CNT_W = ($clog2(rd_latency + 4) > 3) ? $clog2(rd_latency + 4) : 3;
    localparam logic [CNT_W-1:0] WR_HOLD = CNT_W'(3);
    localparam logic [CNT_W-1:0] RD_HOLD = CNT_W'(rd_latency + 3);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        BURST
    } state_t;

    state_t             state;
    logic               gnt;
    logic               last;
    logic               we_r;
    logic [CNT_W-1:0]   cnt;

    logic                 g_stb;
    logic                 g_we;
    logic [fml_depth-1:0] g_adr;
    logic [7:0]           g_sel;
    logic [63:0]          g_do;
    logic                 pick;
    logic                 active;

    // NOTE: every signal written in always_comb gets a value on every path, so no latch is inferred.
    always_comb begin
        g_stb = m0_stb;
        g_we  = m0_we;
        g_adr = m0_adr;
        g_sel = m0_sel;
        g_do  = m0_do;
        if (gnt) begin
            g_stb = m1_stb;
            g_we  = m1_we;
            g_adr = m1_adr;
            g_sel = m1_sel;
            g_do  = m1_do;
        end
    end

    // On a tie the master that was not served last wins.
    assign pick   = (m0_stb && m1_stb) ? ~last : m1_stb;
    assign active = (state != IDLE);

    // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= IDLE;
            gnt   <= 1'b0;
            last  <= 1'b1;
            we_r  <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_stb || m1_stb) begin
                        gnt   <= pick;
                        we_r  <= pick ? m1_we : m0_we;
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (!g_stb) begin
                        state <= IDLE;
                    end else if (fml_ack) begin
                        last  <= gnt;
                        cnt   <= we_r ? WR_HOLD : RD_HOLD;
                        state <= BURST;
                    end
                end
                BURST: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign fml_stb = (state == REQ) && g_stb;
    assign fml_adr = active ? g_adr : '0;
    assign fml_we  = active && g_we;
    assign fml_sel = active ? g_sel : '0;
    assign fml_do  = active ? g_do  : '0;

    assign m0_ack = (state == REQ) && !gnt && m0_stb && fml_ack;
    assign m1_ack = (state == REQ) &&  gnt && m1_stb && fml_ack;

    // Reset gating keeps busy low while the arbiter is held in reset.
    assign busy = active || (sys_rst_n && (m0_stb || m1_stb));

endmodule

// File: tb/tb_tmu2_fmlarb.sv
// Self-checking bench for tmu2_fmlarb: directed scenarios plus randomized bursts
// checked against a transaction-level round-robin model.
module tb_tmu2_fmlarb;
    localparam int FML_DEPTH  = 26;
    localparam int RD_LATENCY = 1;

    logic sys_clk = 1'b0;
    logic sys_rst_n = 1'b0;
    logic busy;
    logic [FML_DEPTH-1:0] m0_adr, m1_adr, fml_adr;
    logic m0_stb, m0_we, m0_ack, m1_stb, m1_we, m1_ack;
    logic fml_stb, fml_we, fml_ack;
    logic [7:0] m0_sel, m1_sel, fml_sel;
    logic [63:0] m0_do, m1_do, fml_do;

    tmu2_fmlarb #(.fml_depth(FML_DEPTH), .rd_latency(RD_LATENCY)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .busy(busy),
        .m0_adr(m0_adr), .m0_stb(m0_stb), .m0_we(m0_we), .m0_sel(m0_sel), .m0_do(m0_do), .m0_ack(m0_ack),
        .m1_adr(m1_adr), .m1_stb(m1_stb), .m1_we(m1_we), .m1_sel(m1_sel), .m1_do(m1_do), .m1_ack(m1_ack),
        .fml_adr(fml_adr), .fml_stb(fml_stb), .fml_we(fml_we), .fml_ack(fml_ack),
        .fml_sel(fml_sel), .fml_do(fml_do)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;

    // Master-side view: pending requests and their attributes.
    bit                   req   [2];
    bit                   we_q  [2];
    logic [FML_DEPTH-1:0] adr_q [2];
    logic [7:0]           sel_q [2];
    logic [63:0]          do_q  [2];
    int                   last_m = 1;

    typedef enum {P_RAND, P_BOTH, P_ONLY0, P_ONLY1} policy_t;

    task automatic step();
        @(posedge sys_clk);
        #2;
    endtask

    task automatic apply();
        m0_stb = req[0]; m0_we = we_q[0]; m0_adr = adr_q[0]; m0_sel = sel_q[0]; m0_do = do_q[0];
        m1_stb = req[1]; m1_we = we_q[1]; m1_adr = adr_q[1]; m1_sel = sel_q[1]; m1_do = do_q[1];
    endtask

    function automatic logic [FML_DEPTH-1:0] rand_adr();
        logic [FML_DEPTH-1:0] a;
        a = FML_DEPTH'($urandom);
        a[4:0] = '0;
        return a;
    endfunction

    task automatic rand_beats();
        for (int m = 0; m < 2; m++) begin
            sel_q[m] = 8'($urandom);
            do_q[m]  = {$urandom, $urandom};
        end
    endtask

    // Release all requests; from REQ or IDLE the arbiter is idle one edge later.
    task automatic drop_requests();
        req[0] = 1'b0; req[1] = 1'b0; fml_ack = 1'b0;
        apply();
        step();
    endtask

    // Serves n bursts starting from an IDLE cycle; the granted master is predicted
    // from the round-robin rule and hold lengths from the burst type.
    task automatic run_bursts(input policy_t pol, input int n, input int we_force, input int d_force);
        int w, d, hold;
        for (int it = 0; it < n; it++) begin
            for (int m = 0; m < 2; m++) begin
                bit want;
                case (pol)
                    P_RAND:  want = 1'($urandom_range(0, 1));
                    P_BOTH:  want = 1'b1;
                    P_ONLY0: want = (m == 0);
                    default: want = (m == 1);
                endcase
                if (want && !req[m]) begin
                    req[m]   = 1'b1;
                    we_q[m]  = (we_force < 0) ? 1'($urandom_range(0, 1)) : we_force[0];
                    adr_q[m] = (pol == P_ONLY0) ? FML_DEPTH'(32'h100) : rand_adr();
                end
            end
            if (!req[0] && !req[1]) begin
                req[0] = 1'b1; we_q[0] = 1'b1; adr_q[0] = rand_adr();
            end
            rand_beats(); fml_ack = 1'b0; apply(); #1;
            checks++; if (fml_stb !== 1'b0) begin errors++; $display("FAIL idle_stb it=%0d: got %b want 0", it, fml_stb); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL idle_busy it=%0d: got %b want 1", it, busy); end
            checks++; if ((|{fml_we, fml_sel, fml_do, fml_adr}) !== 1'b0) begin errors++; $display("FAIL idle_zero it=%0d: adr=%h sel=%h want 0", it, fml_adr, fml_sel); end

            w = (req[0] && req[1]) ? 1 - last_m : (req[1] ? 1 : 0);
            d = (d_force < 0) ? int'($urandom_range(0, 3)) : d_force;
            step();
            for (int k = 0; k <= d; k++) begin
                rand_beats(); fml_ack = (k == d); apply(); #1;
                checks++; if (fml_stb !== 1'b1) begin errors++; $display("FAIL req_stb it=%0d k=%0d: got %b want 1", it, k, fml_stb); end
                checks++;
                if (fml_adr !== adr_q[w] || fml_we !== we_q[w] || fml_sel !== sel_q[w] || fml_do !== do_q[w]) begin
                    errors++; $display("FAIL req_mux it=%0d: adr=%h we=%b want adr=%h we=%b (m%0d)", it, fml_adr, fml_we, adr_q[w], we_q[w], w);
                end
                checks++;
                if (m0_ack !== (k == d && w == 0) || m1_ack !== (k == d && w == 1)) begin
                    errors++; $display("FAIL req_ack it=%0d k=%0d: ack0=%b ack1=%b granted m%0d", it, k, m0_ack, m1_ack, w);
                end
                step();
            end
            req[w] = 1'b0; last_m = w;
            hold = we_q[w] ? 3 : RD_LATENCY + 3;
            for (int b = 1; b <= hold; b++) begin
                rand_beats(); fml_ack = 1'($urandom_range(0, 1)); apply(); #1;
                checks++;
                if (fml_stb !== 1'b0 || busy !== 1'b1 || m0_ack !== 1'b0 || m1_ack !== 1'b0) begin
                    errors++; $display("FAIL burst_ctl it=%0d b=%0d: stb=%b busy=%b ack0=%b ack1=%b want 0 1 0 0", it, b, fml_stb, busy, m0_ack, m1_ack);
                end
                checks++;
                if (fml_sel !== sel_q[w] || fml_do !== do_q[w]) begin
                    errors++; $display("FAIL burst_data it=%0d b=%0d: do=%h want %h", it, b, fml_do, do_q[w]);
                end
                step();
            end
            fml_ack = 1'b0;
        end
    endtask

    task automatic test_reset();
        req[0] = 1'b1; req[1] = 1'b1;
        we_q[0] = 1'b1; we_q[1] = 1'b1;
        adr_q[0] = rand_adr(); adr_q[1] = adr_q[0] ^ FML_DEPTH'(32'h40);
        rand_beats(); apply();
        repeat (3) step();
        #1;
        checks++;
        if ((|{busy, m0_ack, m1_ack, fml_stb, fml_we, fml_sel, fml_do, fml_adr}) !== 1'b0) begin
            errors++; $display("FAIL reset_outputs: busy=%b stb=%b adr=%h want all 0", busy, fml_stb, fml_adr);
        end
        sys_rst_n = 1'b1; #1;
        checks++; if (fml_stb !== 1'b0) begin errors++; $display("FAIL reset_arb_cycle: stb=%b want 0", fml_stb); end
        step(); #1;
        checks++;
        if (fml_stb !== 1'b1 || fml_adr !== adr_q[0]) begin
            errors++; $display("FAIL reset_first_grant: stb=%b adr=%h want 1 %h", fml_stb, fml_adr, adr_q[0]);
        end
        last_m = 1;
        drop_requests();
    endtask

    task automatic test_write_burst();
        run_bursts(P_ONLY0, 1, 1, 2);
        apply(); #1;
        checks++;
        if (busy !== 1'b0 || fml_stb !== 1'b0) begin
            errors++; $display("FAIL write_end_idle: busy=%b stb=%b want 0 0", busy, fml_stb);
        end
        step();
    endtask

    task automatic test_alternation();
        sys_rst_n = 1'b0; #1; sys_rst_n = 1'b1;
        last_m = 1;
        run_bursts(P_BOTH, 4, 1, -1);
        drop_requests();
    endtask

    task automatic test_read_hold();
        req[1] = 1'b1; we_q[1] = 1'b0; adr_q[1] = rand_adr();
        we_q[0] = 1'b1; adr_q[0] = adr_q[1] ^ FML_DEPTH'(32'h40);
        apply(); step();
        fml_ack = 1'b1; apply(); #1;
        checks++;
        if (m1_ack !== 1'b1 || m0_ack !== 1'b0 || fml_adr !== adr_q[1] || fml_we !== 1'b0) begin
            errors++; $display("FAIL read_ack: ack1=%b ack0=%b adr=%h we=%b want 1 0 %h 0", m1_ack, m0_ack, fml_adr, adr_q[1], fml_we);
        end
        step();
        fml_ack = 1'b0; req[1] = 1'b0; last_m = 1;
        for (int b = 1; b <= RD_LATENCY + 3; b++) begin
            if (b == 2) req[0] = 1'b1;
            apply(); #1;
            checks++;
            if (fml_stb !== 1'b0 || m0_ack !== 1'b0 || busy !== 1'b1) begin
                errors++; $display("FAIL read_hold b=%0d: stb=%b ack0=%b busy=%b want 0 0 1", b, fml_stb, m0_ack, busy);
            end
            step();
        end
        #1;
        checks++; if (fml_stb !== 1'b0) begin errors++; $display("FAIL read_arb_cycle: stb=%b want 0", fml_stb); end
        step(); #1;
        checks++;
        if (fml_stb !== 1'b1 || fml_adr !== adr_q[0]) begin
            errors++; $display("FAIL read_next_grant: stb=%b adr=%h want 1 %h", fml_stb, fml_adr, adr_q[0]);
        end
        drop_requests();
    endtask

    task automatic test_abort();
        run_bursts(P_ONLY1, 1, -1, -1);
        req[0] = 1'b1; we_q[0] = 1'b1; adr_q[0] = rand_adr();
        apply(); step(); #1;
        checks++; if (fml_stb !== 1'b1) begin errors++; $display("FAIL abort_req: stb=%b want 1", fml_stb); end
        req[0] = 1'b0; apply(); #1;
        checks++;
        if (fml_stb !== 1'b0 || m0_ack !== 1'b0) begin
            errors++; $display("FAIL abort_drop: stb=%b ack0=%b want 0 0", fml_stb, m0_ack);
        end
        step(); #1;
        checks++;
        if (busy !== 1'b0 || fml_stb !== 1'b0) begin
            errors++; $display("FAIL abort_idle: busy=%b stb=%b want 0 0", busy, fml_stb);
        end
        req[0] = 1'b1; req[1] = 1'b1; adr_q[1] = adr_q[0] ^ FML_DEPTH'(32'h40);
        apply(); step(); #1;
        checks++;
        if (fml_stb !== 1'b1 || fml_adr !== adr_q[1 - last_m]) begin
            errors++; $display("FAIL abort_last_kept: adr=%h want %h", fml_adr, adr_q[1 - last_m]);
        end
        drop_requests();
    endtask

    task automatic test_reset_in_burst();
        req[0] = 1'b1; we_q[0] = 1'b1; adr_q[0] = rand_adr();
        apply(); step();
        fml_ack = 1'b1; apply(); step();
        fml_ack = 1'b0; req[0] = 1'b0; apply(); step();
        rand_beats(); do_q[0][0] = 1'b1;
        req[0] = 1'b1; req[1] = 1'b1; adr_q[1] = adr_q[0] ^ FML_DEPTH'(32'h40);
        apply(); #1;
        checks++; if (fml_do !== do_q[0]) begin errors++; $display("FAIL rst_burst_data: do=%h want %h", fml_do, do_q[0]); end
        sys_rst_n = 1'b0; #1;
        checks++;
        if ((|{busy, m0_ack, m1_ack, fml_stb, fml_we, fml_sel, fml_do, fml_adr}) !== 1'b0) begin
            errors++; $display("FAIL rst_async_zero: busy=%b do=%h adr=%h want all 0", busy, fml_do, fml_adr);
        end
        step();
        sys_rst_n = 1'b1; last_m = 1; #1;
        checks++;
        if (fml_stb !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL rst_release_idle: stb=%b busy=%b want 0 1", fml_stb, busy);
        end
        step(); #1;
        checks++;
        if (fml_stb !== 1'b1 || fml_adr !== adr_q[0]) begin
            errors++; $display("FAIL rst_next_grant: stb=%b adr=%h want 1 %h", fml_stb, fml_adr, adr_q[0]);
        end
        drop_requests();
    endtask

    task automatic test_random();
        run_bursts(P_RAND, 40, -1, -1);
        drop_requests();
    endtask

    initial begin
        fml_ack = 1'b0;
        for (int m = 0; m < 2; m++) begin
            req[m] = 1'b0; we_q[m] = 1'b0; adr_q[m] = '0; sel_q[m] = '0; do_q[m] = '0;
        end
        apply();
        test_reset();
        test_write_burst();
        test_alternation();
        test_read_hold();
        test_abort();
        test_reset_in_burst();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached after %0d checks", checks);
        $fatal(1, "time limit");
    end

endmodule
